// File: rtl/phy_rx_pkg.sv
// Shared constants and FSM encoding for the phy_rx receive path.
package phy_rx_pkg;

  localparam int unsigned DEFAULT_DATA_W = 8;
  localparam int unsigned DEFAULT_DEPTH  = 8;
  localparam int unsigned DROP_CNT_W     = 8;

  typedef enum logic [1:0] {
    StWaitData = 2'd0,
    StActive   = 2'd1,
    StError    = 2'd2
  } link_state_e;

endpackage

// File: rtl/phy_rx_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one registered read port.
// The read register holds its value unless rd_en_i is set.
module phy_rx_fifo_mem
  import phy_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned DEPTH  = DEFAULT_DEPTH
) (
  input  logic                     clk_f,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [DATA_W-1:0]        rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  always_ff @(posedge clk_f) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read samples the pre-write contents, so a full-FIFO push+pop returns the oldest byte.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = mem_q[rd_addr_i];
    end
  end

  always_ff @(posedge clk_f) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/phy_rx_byte_fifo.sv
// Receive byte FIFO with link-state FSM, sticky error flags and registered fill-level flags.
// Define PHY_RX_FIFO_STATS_EN to build the saturating dropped-byte counter.
module phy_rx_byte_fifo
  import phy_rx_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned DEPTH     = DEFAULT_DEPTH,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                    clk_f,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    pop,
  output logic [DATA_W-1:0]       data_out,
  output logic                    valid_out,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    link_up,
  output logic                    overflow_err,
  output logic                    underflow_err,
  output logic [DROP_CNT_W-1:0]   drop_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfCnt    = CntW'(AF_THRESH);
  localparam logic [CntW-1:0] AeCnt    = CntW'(AE_THRESH);

  link_state_e     state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full_q, full_d, empty_q, empty_d;
  logic            afull_q, afull_d, aempty_q, aempty_d;
  logic            valid_out_q, valid_out_d;
  logic            ovf_err_q, ovf_err_d, unf_err_q, unf_err_d;

  logic is_full, pop_acc, push, ovf, unf;

  always_comb begin
    is_full = (count_q == DepthCnt);
    pop_acc = pop && (count_q != '0);
    push    = valid_in && (state_q != StError) && (!is_full || pop_acc);
    ovf     = valid_in && is_full && !pop_acc;
    unf     = pop && (count_q == '0);
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d    = pop_acc ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d     = count_q;
    unique case ({push, pop_acc})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    full_d      = (count_d == DepthCnt);
    empty_d     = (count_d == '0);
    afull_d     = (count_d >= AfCnt);
    aempty_d    = (count_d <= AeCnt);
    valid_out_d = pop_acc;
    ovf_err_d   = ovf_err_q | ovf;
    unf_err_d   = unf_err_q | unf;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitData: if (valid_in) state_d = StActive;
      StActive:   if (ovf || unf) state_d = StError;
      StError:    state_d = StError;
      default:    state_d = StWaitData;
    endcase
  end

  always_ff @(posedge clk_f) begin
    if (!reset) begin
      state_q     <= StWaitData;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      valid_out_q <= 1'b0;
      ovf_err_q   <= 1'b0;
      unf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      valid_out_q <= valid_out_d;
      ovf_err_q   <= ovf_err_d;
      unf_err_q   <= unf_err_d;
    end
  end

  phy_rx_fifo_mem #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_f    (clk_f),
    .reset    (reset),
    .wr_en_i  (push),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(data_in),
    .rd_en_i  (pop_acc),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(data_out)
  );

`ifdef PHY_RX_FIFO_STATS_EN
  logic                  drop;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop       = valid_in && ((state_q == StError) || ovf);
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_f) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

  assign valid_out     = valid_out_q;
  assign fifo_full     = full_q;
  assign fifo_empty    = empty_q;
  assign almost_full   = afull_q;
  assign almost_empty  = aempty_q;
  assign count         = count_q;
  assign link_up       = (state_q == StActive);
  assign overflow_err  = ovf_err_q;
  assign underflow_err = unf_err_q;

endmodule

// File: tb/tb_phy_rx_byte_fifo.sv
// Randomised scoreboard bench for phy_rx_byte_fifo against a queue-based reference model.
module tb_phy_rx_byte_fifo;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int M_WAIT = 0, M_ACT = 1, M_ERR = 2;

  logic       clk_f = 1'b0;
  logic       reset, valid_in, pop;
  logic [7:0] data_in, data_out, drop_count;
  logic       valid_out, fifo_full, fifo_empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       link_up, overflow_err, underflow_err;

  phy_rx_byte_fifo dut (
    .clk_f        (clk_f),
    .reset        (reset),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .link_up      (link_up),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err),
    .drop_count   (drop_count)
  );

  always #5 clk_f = ~clk_f;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: stored bytes, link state, sticky flags, drop tally, last popped byte.
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  int         m_state = M_WAIT;
  bit         m_of, m_uf;
  int         m_drop;
  logic [7:0] m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_drop();
`ifdef PHY_RX_FIFO_STATS_EN
    if (m_drop < 255) m_drop++;
`endif
  endtask

  task automatic model_step(input bit r, input bit v, input logic [7:0] d, input bit p);
    bit pop_ok, full, ovf;
    if (!r) begin
      m_q.delete();
      m_state = M_WAIT;
      m_of = 0; m_uf = 0; m_drop = 0; m_last = 8'h00;
      return;
    end
    pop_ok = p && (m_q.size() > 0);
    full   = (m_q.size() == DEPTH);
    ovf    = v && full && !pop_ok;
    if (pop_ok) begin
      m_last = m_q.pop_front();
      exp_q.push_back(m_last);
    end
    if (p && !pop_ok) m_uf = 1;
    if (ovf) m_of = 1;
    if (v) begin
      if (m_state == M_ERR || ovf) model_drop();
      else m_q.push_back(d);
    end
    if (m_state == M_WAIT && v) m_state = M_ACT;
    else if (m_state == M_ACT && (ovf || (p && !pop_ok))) m_state = M_ERR;
  endtask

  task automatic check_all();
    int n;
    n = m_q.size();
    chk("count", 32'(count), n);
    chk("fifo_full", 32'(fifo_full), 32'(n == DEPTH));
    chk("fifo_empty", 32'(fifo_empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE));
    chk("link_up", 32'(link_up), 32'(m_state == M_ACT));
    chk("overflow_err", 32'(overflow_err), 32'(m_of));
    chk("underflow_err", 32'(underflow_err), 32'(m_uf));
    chk("drop_count", 32'(drop_count), m_drop);
    chk("data_out_hold", 32'(data_out), 32'(m_last));
  endtask

  task automatic cycle(input bit r, input bit v, input logic [7:0] d, input bit p);
    @(negedge clk_f);
    reset    = r;
    valid_in = v;
    data_in  = d;
    pop      = p;
    model_step(r, v, d, p);
    @(posedge clk_f);
    #1;
    check_all();
  endtask

  // Monitor: every presented byte must match the oldest outstanding expected pop.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk_f);
      #1;
      if (valid_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pop_unexpected: got valid_out=1 data 0x%0h want no output at %0t",
                   data_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", 32'(data_out), 32'(e));
        end
      end
    end
  end

  initial begin
    int pv, pp;
    bit v, p, r;
    reset = 1'b0; valid_in = 1'b0; pop = 1'b0; data_in = 8'h00;

    cycle(0, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    repeat (2) cycle(1, 0, 8'h00, 0);

    cycle(1, 1, 8'h11, 0);
    cycle(1, 1, 8'h22, 0);
    cycle(1, 1, 8'h33, 0);
    repeat (3) cycle(1, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 0);

    for (int i = 0; i < 8; i++) cycle(1, 1, 8'hA0 + 8'(i), 0);
    cycle(1, 1, 8'hB0, 1);
    cycle(1, 1, 8'hC0, 0);
    repeat (8) cycle(1, 0, 8'h00, 1);
    cycle(1, 0, 8'h00, 1);
    cycle(1, 1, 8'hD0, 0);
    cycle(1, 0, 8'h00, 0);

    cycle(0, 0, 8'h00, 0);
    cycle(1, 1, 8'hE0, 0);
    cycle(1, 1, 8'hE1, 0);
    cycle(1, 0, 8'h00, 1);
    cycle(0, 1, 8'hE2, 1);
    cycle(1, 0, 8'h00, 0);

    for (int seg = 0; seg < 6; seg++) begin
      pv = 30 + 12 * seg;
      pp = 75 - 10 * seg;
      cycle(0, 0, 8'h00, 0);
      for (int k = 0; k < 350; k++) begin
        v = ($urandom_range(0, 99) < pv);
        p = ($urandom_range(0, 99) < pp) && ((m_q.size() > 0) || ($urandom_range(0, 99) < 3));
        r = ($urandom_range(0, 299) != 0);
        cycle(r, v, 8'($urandom()), p);
      end
    end

    cycle(1, 0, 8'h00, 0);
    @(negedge clk_f);
    chk("pending_pops", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
